// File: rtl/spi_flash_block_arbiter_pkg.sv
// Shared types and defaults for the SPI flash block-read arbiter.
// FSM encoding and default geometry matching spi_flash_ctrl.
package spi_flash_block_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_ADDR_W         = 24;
    localparam int DEF_BLOCK_BITS     = 10;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    // A single requester still needs a 1-bit pointer register.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_flash_block_arbiter_if.sv
// Requester and flash-engine signals of the block arbiter.
// slave is the arbiter's view, master is the surrounding system's view.
interface spi_flash_block_arbiter_if
    import spi_flash_block_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W
) ();

    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
    logic [NUM_REQ-1:0]        o_grant;
    logic [NUM_REQ-1:0]        o_done;
    logic                      o_err;
    logic                      o_busy;
    logic [ADDR_W-1:0]         o_read_addr;
    logic                      o_read_stb;
    logic                      i_read_done_stb;
    logic                      i_invalidate;

    modport slave (
        input  i_req, i_req_addr, i_read_done_stb, i_invalidate,
        output o_grant, o_done, o_err, o_busy, o_read_addr, o_read_stb
    );

    modport master (
        output i_req, i_req_addr, i_read_done_stb, i_invalidate,
        input  o_grant, o_done, o_err, o_busy, o_read_addr, o_read_stb
    );

endinterface

// File: rtl/spi_flash_block_arbiter_rr_arbiter.sv
// Round-robin picker: lowest requester at or above the pointer wins, else wraps.
// Pointer moves to the slot after the finishing owner only on advance.
module spi_flash_block_arbiter_rr_arbiter
    import spi_flash_block_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] owner,
    input  logic               advance,
    output logic [NUM_REQ-1:0] winner
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] upper_req;
    logic               found;

    always_comb begin
        upper_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            upper_req[i] = req[i] && (i >= int'(ptr_q));
        end
    end

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && upper_req[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner[i]) ptr_d = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/spi_flash_block_arbiter.sv
// Shares one spi_flash_ctrl block-read engine and its block BRAM between requesters,
// short-circuiting reads of the resident block and aborting reads that never finish.
module spi_flash_block_arbiter
    import spi_flash_block_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int BLOCK_BITS     = DEF_BLOCK_BITS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic                      wb_clk_i,
    input logic                      wb_rst_i,
    spi_flash_block_arbiter_if.slave bus
);

    localparam int               TAG_W    = ADDR_W - BLOCK_BITS;
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               read_stb_q, read_stb_d;
    logic [ADDR_W-1:0]  read_addr_q, read_addr_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               tag_valid_q, tag_valid_d;
    logic               poison_q, poison_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [NUM_REQ-1:0] winner;
    logic [TAG_W-1:0]   win_tag;
    logic               arb_advance;

    assign arb_advance = (state_q == ST_DONE);

    spi_flash_block_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .req     (bus.i_req),
        .owner   (grant_q),
        .advance (arb_advance),
        .winner  (winner)
    );

    always_comb begin
        win_tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) win_tag = bus.i_req_addr[i*ADDR_W + BLOCK_BITS +: TAG_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        err_d       = 1'b0;
        read_addr_d = read_addr_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        poison_d    = poison_q;
        timer_d     = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (|winner) begin
                    grant_d = winner;
                    if (tag_valid_q && !bus.i_invalidate && (tag_q == win_tag)) begin
                        state_d = ST_DONE;
                    end else begin
                        read_addr_d = {win_tag, {BLOCK_BITS{1'b0}}};
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                timer_d  = '0;
                poison_d = 1'b0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (timer_q != '1) timer_d = timer_q + 1'b1;
                if (bus.i_read_done_stb) begin
                    tag_d       = read_addr_q[ADDR_W-1:BLOCK_BITS];
                    tag_valid_d = !poison_q;
                    state_d     = ST_DONE;
                end else if (timer_q == TMR_LAST) begin
                    tag_valid_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Invalidate overrides any fill landing in the same cycle and poisons one in flight.
        if (bus.i_invalidate) begin
            tag_valid_d = 1'b0;
            if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) poison_d = 1'b1;
        end
        if (state_d == ST_DONE) done_d = grant_d;
        read_stb_d = (state_d == ST_ISSUE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            read_stb_q  <= 1'b0;
            read_addr_q <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            poison_q    <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            read_stb_q  <= read_stb_d;
            read_addr_q <= read_addr_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            poison_q    <= poison_d;
            timer_q     <= timer_d;
        end
    end

    assign bus.o_grant     = grant_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_read_addr = read_addr_q;
    assign bus.o_read_stb  = read_stb_q;

endmodule

// File: tb/tb_spi_flash_block_arbiter.sv
// Bench for spi_flash_block_arbiter: two instances, the second with a short timeout.
// Expected completions are queued at request time and popped when o_done fires.
`timescale 1ns/1ps
module tb_spi_flash_block_arbiter;

    localparam int NR = 2;
    localparam int AW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_flash_block_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW)) bus_a ();
    spi_flash_block_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW)) bus_b ();

    spi_flash_block_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .BLOCK_BITS(10), .TIMEOUT_CYCLES(200)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus_a)
    );

    spi_flash_block_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .BLOCK_BITS(10), .TIMEOUT_CYCLES(16)
    ) dut_to (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus_b)
    );

    typedef struct packed {
        logic [NR-1:0] done;
        logic          err;
        logic [AW-1:0] raddr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   stb_a   = 0;
    int   stb_b   = 0;
    int   overlap = 0;
    int   mptr[2];

    always @(posedge clk) begin
        if (bus_a.o_read_stb) stb_a++;
        if (bus_b.o_read_stb) stb_b++;
    end

    always @(negedge clk) begin
        if ($countones(bus_a.o_grant) > 1) overlap++;
    end

    function automatic logic [NR-1:0] model_pick(input logic [NR-1:0] req, input int ptr);
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (ptr + k) % NR;
            if (req[j]) return NR'(1) << j;
        end
        return '0;
    endfunction

    function automatic void push_exp(input int sel, input logic [NR-1:0] req,
                                     input logic err, input logic [AW-1:0] raddr);
        exp_t          e;
        logic [NR-1:0] own;
        own = model_pick(req, mptr[sel]);
        for (int i = 0; i < NR; i++) if (own[i]) mptr[sel] = (i + 1) % NR;
        e.done  = own;
        e.err   = err;
        e.raddr = raddr;
        exp_q.push_back(e);
    endfunction

    task automatic wait_done(input bit sel, input int limit, output int n);
        n = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if ((sel ? bus_b.o_done : bus_a.o_done) != '0) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus_a.o_grant, bus_a.o_done, bus_a.o_err, bus_a.o_busy, bus_a.o_read_addr, bus_a.o_read_stb} !== '0) begin
            n_bad++;
            $display("FAIL reset_a: outputs=%h want 0", {bus_a.o_grant, bus_a.o_done, bus_a.o_err, bus_a.o_busy, bus_a.o_read_addr, bus_a.o_read_stb});
        end
        n_cmp++;
        if ({bus_b.o_grant, bus_b.o_done, bus_b.o_err, bus_b.o_busy, bus_b.o_read_addr, bus_b.o_read_stb} !== '0) begin
            n_bad++;
            $display("FAIL reset_b: outputs=%h want 0", {bus_b.o_grant, bus_b.o_done, bus_b.o_err, bus_b.o_busy, bus_b.o_read_addr, bus_b.o_read_stb});
        end
        rst     = 1'b0;
        mptr[0] = 0;
        mptr[1] = 0;
        exp_q.delete();
    endtask

    task automatic test_miss();
        int   n;
        int   s0;
        exp_t e;
        @(negedge clk);
        s0 = stb_a;
        bus_a.i_req_addr[0 +: AW] = 24'h012345;
        bus_a.i_req = 2'b01;
        push_exp(0, 2'b01, 1'b0, 24'h012000);
        @(negedge clk);
        n_cmp++;
        if (bus_a.o_read_stb !== 1'b1 || bus_a.o_read_addr !== exp_q[0].raddr) begin
            n_bad++;
            $display("FAIL miss_issue: stb=%b addr=%h want stb=1 addr=%h", bus_a.o_read_stb, bus_a.o_read_addr, exp_q[0].raddr);
        end
        n_cmp++;
        if (bus_a.o_grant !== exp_q[0].done || bus_a.o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL miss_grant: grant=%b busy=%b want grant=%b busy=1", bus_a.o_grant, bus_a.o_busy, exp_q[0].done);
        end
        repeat (50) @(negedge clk);
        n_cmp++;
        if (bus_a.o_done !== 2'b00) begin
            n_bad++;
            $display("FAIL miss_early_done: done=%b want 00", bus_a.o_done);
        end
        bus_a.i_read_done_stb = 1'b1;
        wait_done(0, 3, n);
        bus_a.i_read_done_stb = 1'b0;
        bus_a.i_req = 2'b00;
        pop_exp(e);
        n_cmp++;
        if (n != 1 || bus_a.o_done !== e.done || bus_a.o_err !== e.err) begin
            n_bad++;
            $display("FAIL miss_done: latency=%0d done=%b err=%b want latency=1 done=%b err=%b", n, bus_a.o_done, bus_a.o_err, e.done, e.err);
        end
        n_cmp++;
        if (stb_a - s0 != 1) begin
            n_bad++;
            $display("FAIL miss_stb_count: got %0d want 1", stb_a - s0);
        end
        @(negedge clk);
        n_cmp++;
        if (bus_a.o_busy !== 1'b0 || bus_a.o_grant !== 2'b00) begin
            n_bad++;
            $display("FAIL miss_release: busy=%b grant=%b want 0/00", bus_a.o_busy, bus_a.o_grant);
        end
    endtask

    task automatic test_hit();
        int   n;
        int   s0;
        exp_t e;
        @(negedge clk);
        s0 = stb_a;
        bus_a.i_req_addr[0 +: AW] = 24'h0123FC;
        bus_a.i_req = 2'b01;
        push_exp(0, 2'b01, 1'b0, 24'h012000);
        wait_done(0, 5, n);
        bus_a.i_req = 2'b00;
        pop_exp(e);
        n_cmp++;
        if (n != 1 || bus_a.o_done !== e.done || bus_a.o_err !== e.err) begin
            n_bad++;
            $display("FAIL hit_done: latency=%0d done=%b err=%b want latency=1 done=%b err=%b", n, bus_a.o_done, bus_a.o_err, e.done, e.err);
        end
        @(negedge clk);
        n_cmp++;
        if (stb_a != s0 || bus_a.o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_no_stb: stb_pulses=%0d busy=%b want 0/0", stb_a - s0, bus_a.o_busy);
        end
    endtask

    task automatic test_fairness();
        int   n;
        int   s0;
        int   ov0;
        exp_t e;
        @(negedge clk);
        s0  = stb_a;
        ov0 = overlap;
        bus_a.i_req_addr = {24'h0123F0, 24'h012000};
        for (int k = 0; k < 4; k++) push_exp(0, 2'b11, 1'b0, 24'h012000);
        bus_a.i_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_done(0, 6, n);
            if (k == 3) bus_a.i_req = 2'b00;
            pop_exp(e);
            n_cmp++;
            if (n < 0 || bus_a.o_done !== e.done || bus_a.o_grant !== e.done) begin
                n_bad++;
                $display("FAIL fair_grant_%0d: latency=%0d done=%b grant=%b want %b", k, n, bus_a.o_done, bus_a.o_grant, e.done);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (overlap != ov0 || stb_a != s0) begin
            n_bad++;
            $display("FAIL fair_overlap: overlaps=%0d stb_pulses=%0d want 0/0", overlap - ov0, stb_a - s0);
        end
    endtask

    task automatic test_invalidate();
        int   n;
        int   s0;
        exp_t e;
        @(negedge clk);
        s0 = stb_a;
        bus_a.i_req_addr[0 +: AW] = 24'h0AB000;
        bus_a.i_req = 2'b01;
        push_exp(0, 2'b01, 1'b0, 24'h0AB000);
        repeat (2) @(negedge clk);
        bus_a.i_invalidate = 1'b1;
        @(negedge clk);
        bus_a.i_invalidate = 1'b0;
        repeat (3) @(negedge clk);
        bus_a.i_read_done_stb = 1'b1;
        wait_done(0, 3, n);
        bus_a.i_read_done_stb = 1'b0;
        bus_a.i_req = 2'b00;
        pop_exp(e);
        n_cmp++;
        if (n != 1 || bus_a.o_done !== e.done || bus_a.o_err !== e.err) begin
            n_bad++;
            $display("FAIL inv_fill_done: latency=%0d done=%b err=%b want 1/%b/%b", n, bus_a.o_done, bus_a.o_err, e.done, e.err);
        end
        @(negedge clk);
        bus_a.i_req = 2'b01;
        push_exp(0, 2'b01, 1'b0, 24'h0AB000);
        @(negedge clk);
        n_cmp++;
        if (bus_a.o_read_stb !== 1'b1 || bus_a.o_read_addr !== exp_q[0].raddr) begin
            n_bad++;
            $display("FAIL inv_remiss: stb=%b addr=%h want stb=1 addr=%h", bus_a.o_read_stb, bus_a.o_read_addr, exp_q[0].raddr);
        end
        @(negedge clk);
        bus_a.i_read_done_stb = 1'b1;
        wait_done(0, 3, n);
        bus_a.i_read_done_stb = 1'b0;
        bus_a.i_req = 2'b00;
        pop_exp(e);
        n_cmp++;
        if (n != 1 || bus_a.o_done !== e.done) begin
            n_bad++;
            $display("FAIL inv_refill_done: latency=%0d done=%b want 1/%b", n, bus_a.o_done, e.done);
        end
        @(negedge clk);
        bus_a.i_req = 2'b01;
        push_exp(0, 2'b01, 1'b0, 24'h0AB000);
        wait_done(0, 5, n);
        bus_a.i_req = 2'b00;
        pop_exp(e);
        n_cmp++;
        if (n != 1 || bus_a.o_done !== e.done || stb_a - s0 != 2) begin
            n_bad++;
            $display("FAIL inv_then_hit: latency=%0d done=%b stb_pulses=%0d want 1/%b/2", n, bus_a.o_done, stb_a - s0, e.done);
        end
    endtask

    task automatic test_timeout();
        int   n;
        int   s0;
        exp_t e;
        @(negedge clk);
        s0 = stb_b;
        bus_b.i_req_addr[0 +: AW] = 24'h0007FF;
        bus_b.i_req = 2'b01;
        push_exp(1, 2'b01, 1'b1, 24'h000400);
        @(negedge clk);
        n_cmp++;
        if (bus_b.o_read_stb !== 1'b1 || bus_b.o_read_addr !== exp_q[0].raddr) begin
            n_bad++;
            $display("FAIL to_issue: stb=%b addr=%h want stb=1 addr=%h", bus_b.o_read_stb, bus_b.o_read_addr, exp_q[0].raddr);
        end
        // WAIT is entered one cycle after the strobe; abort lands 16 cycles later.
        wait_done(1, 40, n);
        bus_b.i_req = 2'b00;
        pop_exp(e);
        n_cmp++;
        if (n != 17 || bus_b.o_done !== e.done || bus_b.o_err !== e.err || bus_b.o_grant !== e.done) begin
            n_bad++;
            $display("FAIL to_abort: cycles_after_wait=%0d done=%b err=%b grant=%b want 16/%b/%b/%b", n - 1, bus_b.o_done, bus_b.o_err, bus_b.o_grant, e.done, e.err, e.done);
        end
        @(negedge clk);
        n_cmp++;
        if (bus_b.o_err !== 1'b0 || bus_b.o_busy !== 1'b0 || stb_b - s0 != 1) begin
            n_bad++;
            $display("FAIL to_after: err=%b busy=%b stb_pulses=%0d want 0/0/1", bus_b.o_err, bus_b.o_busy, stb_b - s0);
        end
        bus_b.i_read_done_stb = 1'b1;
        @(negedge clk);
        bus_b.i_read_done_stb = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus_b.o_done !== 2'b00 || bus_b.o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL to_stray_done: done=%b busy=%b want 00/0", bus_b.o_done, bus_b.o_busy);
        end
        bus_b.i_req = 2'b01;
        push_exp(1, 2'b01, 1'b0, 24'h000400);
        @(negedge clk);
        n_cmp++;
        if (bus_b.o_read_stb !== 1'b1) begin
            n_bad++;
            $display("FAIL to_tag_cleared: stb=%b want 1", bus_b.o_read_stb);
        end
        @(negedge clk);
        bus_b.i_read_done_stb = 1'b1;
        wait_done(1, 3, n);
        bus_b.i_read_done_stb = 1'b0;
        bus_b.i_req = 2'b00;
        pop_exp(e);
        n_cmp++;
        if (n != 1 || bus_b.o_done !== e.done || bus_b.o_err !== e.err) begin
            n_bad++;
            $display("FAIL to_refill: latency=%0d done=%b err=%b want 1/%b/%b", n, bus_b.o_done, bus_b.o_err, e.done, e.err);
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        bus_a.i_req_addr[0 +: AW] = 24'h055123;
        bus_a.i_req = 2'b01;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus_a.o_busy !== 1'b1 || bus_a.o_grant !== 2'b01) begin
            n_bad++;
            $display("FAIL rstw_in_wait: busy=%b grant=%b want 1/01", bus_a.o_busy, bus_a.o_grant);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus_a.o_grant, bus_a.o_done, bus_a.o_err, bus_a.o_busy, bus_a.o_read_addr, bus_a.o_read_stb} !== '0) begin
            n_bad++;
            $display("FAIL rstw_outputs: outputs=%h want 0", {bus_a.o_grant, bus_a.o_done, bus_a.o_err, bus_a.o_busy, bus_a.o_read_addr, bus_a.o_read_stb});
        end
        rst = 1'b0;
        mptr[0] = 0;
        mptr[1] = 0;
        bus_a.i_req = 2'b00;
        bus_a.i_read_done_stb = 1'b1;
        @(negedge clk);
        bus_a.i_read_done_stb = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus_a.o_done !== 2'b00 || bus_a.o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rstw_stale_done: done=%b busy=%b want 00/0", bus_a.o_done, bus_a.o_busy);
        end
    endtask

    initial begin
        bus_a.i_req = '0;
        bus_a.i_req_addr = '0;
        bus_a.i_read_done_stb = 1'b0;
        bus_a.i_invalidate = 1'b0;
        bus_b.i_req = '0;
        bus_b.i_req_addr = '0;
        bus_b.i_read_done_stb = 1'b0;
        bus_b.i_invalidate = 1'b0;
        test_reset();
        test_miss();
        test_hit();
        test_fairness();
        test_invalidate();
        test_timeout();
        test_reset_in_wait();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
